echo_tap_sequencer: RTL and testbench

ECHO_TAP_SEQUENCER -- requirements
Module: echo_tap_sequencer

---
 rtl/audio_fx_pkg.sv | 27 ++
 rtl/echo_tap_sequencer_mix.sv | 46 ++++
 rtl/echo_tap_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_echo_tap_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_fx_pkg.sv
`default_nettype none
// ============================================================================
// audio_fx_pkg : shared widths, sequencer state encoding, saturation limits
// Rev 1.0
// ============================================================================
package audio_fx_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 24;

    localparam logic [DATA_W_DEF-1:0] SAT_MAX_DEF = 16'h7FFF;
    localparam logic [DATA_W_DEF-1:0] SAT_MIN_DEF = 16'h8000;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CAPTURE = 4'd1,
        ST_WR_REQ  = 4'd2,
        ST_WR_WAIT = 4'd3,
        ST_RD_REQ  = 4'd4,
        ST_RD_WAIT = 4'd5,
        ST_MIX     = 4'd6,
        ST_OUT     = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/echo_tap_sequencer_mix.sv
`default_nettype none
// ============================================================================
// echo_mix : sample + (echo >>> (gain_sh+1)), wraps or saturates (ECHO_TAP_SAT_EN)
// Rev 1.0
// ============================================================================
module echo_mix
    import audio_fx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] echo,
    input  logic [1:0]        gain_sh,
    output logic [DATA_W-1:0] mix
);

    logic signed [DATA_W-1:0] shifted;

    always_comb begin
        shifted = $signed(echo) >>> ({1'b0, gain_sh} + 3'd1);
    end

`ifdef ECHO_TAP_SAT_EN
    localparam logic [DATA_W-1:0] SAT_MAX = (DATA_W == DATA_W_DEF) ? DATA_W'(SAT_MAX_DEF)
                                                                  : {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = (DATA_W == DATA_W_DEF) ? DATA_W'(SAT_MIN_DEF)
                                                                  : {1'b1, {(DATA_W-1){1'b0}}};
    logic [DATA_W:0] sum;

    always_comb begin
        sum = {sample[DATA_W-1], sample} + {shifted[DATA_W-1], shifted};
        // The two top bits disagree only when the true result left the DATA_W range
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            mix = sum[DATA_W] ? SAT_MIN : SAT_MAX;
        end else begin
            mix = sum[DATA_W-1:0];
        end
    end
`else
    always_comb begin
        mix = sample + shifted;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/echo_tap_sequencer.sv
`default_nettype none
// ============================================================================
// echo_tap_sequencer : one capture/write/read/mix/output pass per reset window
// Rev 1.0   (build option: ECHO_TAP_SAT_EN selects saturating mix)
// ============================================================================
module echo_tap_sequencer
    import audio_fx_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 512
) (
    input  logic              CLOCK_50_D,
    input  logic              AUD_ADCLRCK,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] wr_ptr,
    input  logic [ADDR_W-1:0] delay,
    input  logic [1:0]        gain_sh,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_enable,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_rd_enable,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_ready,
    input  logic              mem_busy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              rd_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t              state_q,      state_d;
    logic                in_ready_q,   in_ready_d;
    logic [DATA_W-1:0]   sample_q,     sample_d;
    logic [ADDR_W-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [DATA_W-1:0]   echo_q,       echo_d;
    logic                hold_q,       hold_d;
    logic [CNT_W-1:0]    tmo_cnt_q,    tmo_cnt_d;
    logic                wr_en_q,      wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q,    wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q,    wr_data_d;
    logic                rd_en_q,      rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q,    rd_addr_d;
    logic [DATA_W-1:0]   out_data_q,   out_data_d;
    logic                out_valid_q,  out_valid_d;
    logic                done_q,       done_d;
    logic                rd_timeout_q, rd_timeout_d;
    logic [DATA_W-1:0]   mix;

    echo_mix #(.DATA_W(DATA_W)) u_mix (
        .sample  (sample_q),
        .echo    (echo_q),
        .gain_sh (gain_sh),
        .mix     (mix)
    );

    // Strobes default low so every request is a single-cycle pulse
    always_comb begin
        state_d      = state_q;
        in_ready_d   = 1'b0;
        sample_d     = sample_q;
        wr_ptr_d     = wr_ptr_q;
        echo_d       = echo_q;
        hold_d       = 1'b0;
        tmo_cnt_d    = '0;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        done_d       = done_q;
        rd_timeout_d = rd_timeout_q;
        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                state_d    = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (in_valid && in_ready_q) begin
                    sample_d = in_data;
                    wr_ptr_d = wr_ptr;
                    echo_d   = '0;
                    state_d  = ST_WR_REQ;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_WR_REQ: begin
                if (!mem_busy) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_ptr_q;
                    wr_data_d = sample_q;
                    state_d   = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                // First cycle gives the controller time to raise busy for our write
                hold_d = 1'b1;
                if (hold_q && !mem_busy) begin
                    hold_d = 1'b0;
                    if (delay != '0) begin
                        state_d = ST_RD_REQ;
                    end else begin
                        echo_d  = '0;
                        state_d = ST_MIX;
                    end
                end
            end
            ST_RD_REQ: begin
                if (!mem_busy) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = wr_ptr_q - delay;
                    state_d   = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rd_ready) begin
                    echo_d  = mem_rd_data;
                    state_d = ST_MIX;
                end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    rd_timeout_d = 1'b1;
                    echo_d       = '0;
                    state_d      = ST_MIX;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            ST_MIX: begin
                out_data_d  = mix;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50_D or posedge AUD_ADCLRCK) begin
        if (AUD_ADCLRCK) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b0;
            sample_q     <= '0;
            wr_ptr_q     <= '0;
            echo_q       <= '0;
            hold_q       <= 1'b0;
            tmo_cnt_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            rd_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            sample_q     <= sample_d;
            wr_ptr_q     <= wr_ptr_d;
            echo_q       <= echo_d;
            hold_q       <= hold_d;
            tmo_cnt_q    <= tmo_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
            rd_timeout_q <= rd_timeout_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_wr_enable = wr_en_q;
    assign mem_wr_addr   = wr_addr_q;
    assign mem_wr_data   = wr_data_q;
    assign mem_rd_enable = rd_en_q;
    assign mem_rd_addr   = rd_addr_q;
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign done          = done_q;
    assign rd_timeout    = rd_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_echo_tap_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_echo_tap_sequencer : scoreboard bench with a latency-programmable memory model
// Rev 1.0
// ============================================================================
module tb_echo_tap_sequencer;

    localparam int DW  = 16;
    localparam int AW  = 24;
    localparam int TMO = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] wr_ptr = '0;
    logic [AW-1:0] delay = '0;
    logic [1:0]    gain_sh = '0;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_wr_enable;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rd_enable;
    logic [DW-1:0] mem_rd_data = '0;
    logic          mem_rd_ready = 1'b0;
    logic          mem_busy = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          done;
    logic          rd_timeout;

    echo_tap_sequencer #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
        .CLOCK_50_D    (clk),
        .AUD_ADCLRCK   (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .wr_ptr        (wr_ptr),
        .delay         (delay),
        .gain_sh       (gain_sh),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_enable (mem_wr_enable),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_enable (mem_rd_enable),
        .mem_rd_data   (mem_rd_data),
        .mem_rd_ready  (mem_rd_ready),
        .mem_busy      (mem_busy),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .done          (done),
        .rd_timeout    (rd_timeout)
    );

    always #5 clk = ~clk;

    int            passed = 0;
    int            total  = 0;
    logic [DW-1:0] sb_q[$];

    int            wr_cnt, rd_cnt, both_cnt, ovalid_cnt;
    time           wr_t, rd_t, tmo_t, drop_t;
    logic          tmo_seen;
    logic [AW-1:0] wr_addr_seen, rd_addr_seen;
    logic [DW-1:0] wr_data_seen;
    int            rd_lat = -1;
    int            rd_cd  = -1;
    logic [DW-1:0] rd_val = '0;

    // Memory responder and bus monitor, both on the falling edge
    initial forever begin
        @(negedge clk);
        mem_rd_ready = 1'b0;
        if (rd_cd == 0) begin
            mem_rd_ready = 1'b1;
            mem_rd_data  = rd_val;
            rd_cd        = -1;
        end else if (rd_cd > 0) begin
            rd_cd--;
        end
        if (mem_rd_enable && rd_lat >= 0) rd_cd = rd_lat;
        if (mem_wr_enable) begin
            wr_cnt++; wr_t = $time; wr_addr_seen = mem_wr_addr; wr_data_seen = mem_wr_data;
        end
        if (mem_rd_enable) begin
            rd_cnt++; rd_t = $time; rd_addr_seen = mem_rd_addr;
        end
        if (mem_wr_enable && mem_rd_enable) both_cnt++;
        if (rd_timeout && !tmo_seen) begin tmo_seen = 1'b1; tmo_t = $time; end
        if (out_valid) ovalid_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    function automatic logic [DW-1:0] model(input logic [DW-1:0] s, input logic [DW-1:0] e,
                                            input logic [1:0] g);
        int sum;
        sum = int'($signed(s)) + (int'($signed(e)) >>> (int'(g) + 1));
`ifdef ECHO_TAP_SAT_EN
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
`endif
        return DW'(sum);
    endfunction

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mem_busy = 1'b0; rd_cd = -1;
        repeat (2) @(negedge clk);
        wr_cnt = 0; rd_cnt = 0; both_cnt = 0; ovalid_cnt = 0; tmo_seen = 1'b0;
        rst = 1'b0;
    endtask

    task automatic do_frame(input logic [DW-1:0] smp, input logic [AW-1:0] wp,
                            input logic [AW-1:0] dly, input logic [1:0] gs,
                            input logic [DW-1:0] rdv, input int lat, input int busy_n,
                            input int stall, input logic [DW-1:0] exp_out,
                            input logic [AW-1:0] exp_rd_addr, input logic exp_tmo,
                            input string name);
        int n;
        logic [DW-1:0] first_out;
        logic [DW-1:0] exp_pop;
        rd_lat = lat; rd_val = rdv;
        apply_reset();
        mem_busy = (busy_n > 0);
        in_data = smp; wr_ptr = wp; delay = dly; gain_sh = gs; in_valid = 1'b1;
        sb_q.push_back(exp_out);
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        total++;
        if (!in_ready) $display("FAIL %s accept: in_ready=%0b want 1", name, in_ready);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0; in_data = ~smp; wr_ptr = ~wp;
        total++;
        if (in_ready !== 1'b0) $display("FAIL %s in_ready_drop: got %0b want 0", name, in_ready);
        else passed++;
        if (busy_n > 0) begin
            repeat (busy_n) @(negedge clk);
            total++;
            if (wr_cnt != 0) $display("FAIL %s wr_while_busy: got %0d writes want 0", name, wr_cnt);
            else passed++;
            mem_busy = 1'b0; drop_t = $time;
        end
        n = 0;
        while (!out_valid && n < TMO + 100) begin @(negedge clk); n++; end
        total++;
        if (!out_valid) $display("FAIL %s out_valid: got 0 want 1 within %0d cycles", name, TMO + 100);
        else passed++;
        first_out = out_data;
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== first_out)
                $display("FAIL %s hold: got valid=%0b data=%h want 1/%h", name, out_valid, out_data, first_out);
            else passed++;
        end
        out_ready = 1'b1;
        total++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s scoreboard: got empty queue want one entry", name);
        end else begin
            exp_pop = sb_q.pop_front();
            if (out_data !== exp_pop) $display("FAIL %s out_data: got %h want %h", name, out_data, exp_pop);
            else passed++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL %s done: got done=%0b valid=%0b want 1/0", name, done, out_valid);
        else passed++;
        total++;
        if (wr_cnt != 1 || wr_addr_seen !== wp || wr_data_seen !== smp)
            $display("FAIL %s write: got n=%0d @%h d=%h want 1 @%h d=%h", name, wr_cnt, wr_addr_seen, wr_data_seen, wp, smp);
        else passed++;
        total++;
        if (rd_cnt != ((dly != '0) ? 1 : 0))
            $display("FAIL %s rd_count: got %0d want %0d", name, rd_cnt, (dly != '0) ? 1 : 0);
        else passed++;
        if (dly != '0) begin
            total++;
            if (rd_addr_seen !== exp_rd_addr) $display("FAIL %s rd_addr: got %h want %h", name, rd_addr_seen, exp_rd_addr);
            else passed++;
        end
        total++;
        if (both_cnt != 0 || rd_timeout !== exp_tmo)
            $display("FAIL %s flags: got overlap=%0d tmo=%0b want 0/%0b", name, both_cnt, rd_timeout, exp_tmo);
        else passed++;
        if (exp_tmo) begin
            total++;
            if (tmo_t - rd_t != TMO * 10)
                $display("FAIL %s tmo_time: got %0t want %0d", name, tmo_t - rd_t, TMO * 10);
            else passed++;
        end
        if (busy_n > 0) begin
            total++;
            if (wr_t - drop_t != 10) $display("FAIL %s wr_after_busy: got %0t want 10", name, wr_t - drop_t);
            else passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; mem_rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, mem_wr_enable, mem_rd_enable, out_valid, done, rd_timeout} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000",
                     {in_ready, mem_wr_enable, mem_rd_enable, out_valid, done, rd_timeout});
        else passed++;
        total++;
        if ({mem_wr_addr, mem_wr_data, mem_rd_addr, out_data} !== '0)
            $display("FAIL reset_data: got %h %h %h %h want 0", mem_wr_addr, mem_wr_data, mem_rd_addr, out_data);
        else passed++;
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_saturation();
`ifdef ECHO_TAP_SAT_EN
        do_frame(16'h7000, 24'd10, 24'd1, 2'd0, 16'h7FFF, 1, 0, 0, 16'h7FFF, 24'd9, 1'b0, "sat_pos");
        do_frame(16'h8000, 24'd10, 24'd3, 2'd0, 16'h8000, 0, 0, 1, 16'h8000, 24'd7, 1'b0, "sat_neg");
`else
        do_frame(16'h7000, 24'd10, 24'd1, 2'd0, 16'h7FFF, 1, 0, 0, 16'hAFFF, 24'd9, 1'b0, "wrap_pos");
        do_frame(16'h8000, 24'd10, 24'd3, 2'd0, 16'h8000, 0, 0, 1, 16'h4000, 24'd7, 1'b0, "wrap_neg");
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] s, e;
            logic [AW-1:0] wp, dl;
            logic [1:0]    g;
            s  = DW'($urandom);
            e  = DW'($urandom);
            wp = AW'($urandom);
            dl = AW'($urandom_range(1, 5000));
            g  = 2'($urandom_range(0, 3));
            do_frame(s, wp, dl, g, e, int'($urandom_range(0, 6)), 0, int'($urandom_range(0, 3)),
                     model(s, e, g), wp - dl, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid();
        int n;
        rd_lat = -1;
        apply_reset();
        in_data = 16'h2222; wr_ptr = 24'd500; delay = 24'd8; gain_sh = 2'd1; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (rd_cnt == 0 && n < 50) begin @(negedge clk); n++; end
        total++;
        if (rd_cnt == 0) $display("FAIL mid_read_issued: got 0 reads want 1");
        else passed++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({in_ready, mem_wr_enable, mem_rd_enable, out_valid, done, rd_timeout} !== 6'b0 ||
            {mem_wr_addr, mem_wr_data, mem_rd_addr, out_data} !== '0)
            $display("FAIL mid_reset_outputs: got flags=%b wa=%h ra=%h want all 0",
                     {in_ready, mem_wr_enable, mem_rd_enable, out_valid, done, rd_timeout}, mem_wr_addr, mem_rd_addr);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (ovalid_cnt != 0) $display("FAIL mid_no_output: got %0d valid cycles want 0", ovalid_cnt);
        else passed++;
        do_frame(16'h0400, 24'd20, 24'd2, 2'd2, 16'hF000, 3, 0, 0, 16'h0200, 24'd18, 1'b0, "after_mid");
    endtask

    initial begin
        test_reset();
        do_frame(16'h1000, 24'd100, 24'd4, 2'd0, 16'h0800, 2, 0, 2, 16'h1400, 24'd96, 1'b0, "basic");
        do_frame(16'h0123, 24'd2, 24'd5, 2'd1, 16'h4000, 0, 0, 0, 16'h1123, 24'hFFFFFD, 1'b0, "wrap_addr");
        test_saturation();
        do_frame(16'h1234, 24'd50, 24'd7, 2'd2, 16'h7777, -1, 0, 0, 16'h1234, 24'd43, 1'b1, "timeout");
        do_frame(16'hF000, 24'd300, 24'd0, 2'd3, 16'h5555, 1, 20, 1, 16'hF000, 24'd0, 1'b0, "busy_delay0");
        test_random();
        test_reset_mid();
        total++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
